// File: rtl/decode_byte_queue_ctrl.sv
// decode_byte_queue_ctrl: instruction byte queue between fetch and decode.
// A circular byte buffer takes whole fetch lines at the tail. It shows decode a
// window of LINE_BYTES bytes starting at head. Head advances by the decoded
// instruction length.
// Optional feature: define DBQ_STALL_CNT_EN to add the stall_cycles counter.
module decode_byte_queue_ctrl #(
    parameter int unsigned LINE_BYTES  = 16,
    parameter int unsigned DEPTH_LINES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [LINE_BYTES*8-1:0]   fetch_line,
    input  logic                      fetch_valid,
    output logic                      fetch_ready,
    output logic [LINE_BYTES*8-1:0]   window,
    output logic                      window_valid,
    input  logic                      consume,
    input  logic [3:0]                consume_len,
    output logic                      consume_err,
    output logic [5:0]                count
`ifdef DBQ_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cycles
`endif
);

    localparam int unsigned BUF_BYTES = LINE_BYTES * DEPTH_LINES;
    localparam int unsigned PTR_W     = $clog2(BUF_BYTES);
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned LEN_W     = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_READY   = 2'd2,
        ST_FULL    = 2'd3
    } state_t;

    logic [7:0]       mem_q [BUF_BYTES];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    state_t           state_q;
    state_t           state_next;
    logic [CNT_W-1:0] count_next;
    logic             fetch_acc;
    logic             consume_acc;
    logic             consume_bad;

    // Occupancy class thresholds, in bytes.
    localparam logic [CNT_W-1:0] LINE_CNT  = CNT_W'(LINE_BYTES);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_BYTES);
    localparam logic [CNT_W-1:0] ROOM_CNT  = CNT_W'(BUF_BYTES - LINE_BYTES);

    // Handshake qualification, next occupancy and next controller state.
    always_comb begin
        fetch_ready  = 1'b0;
        window_valid = 1'b0;
        fetch_acc    = 1'b0;
        consume_acc  = 1'b0;
        consume_bad  = 1'b0;
        count_next   = count;
        state_next   = state_q;

        fetch_ready  = (state_q != ST_FULL) && (count <= ROOM_CNT);
        window_valid = (state_q == ST_READY) || (state_q == ST_FULL);
        fetch_acc    = fetch_valid & fetch_ready & ~flush;
        consume_acc  = consume & window_valid & (consume_len != LEN_W'(0)) & ~flush;
        consume_bad  = consume & ~flush & ((consume_len == LEN_W'(0)) | ~window_valid);

        // Fetch only accepted with count <= BUF-LINE, consume only with
        // count >= LINE and len < LINE, so neither bound can be crossed.
        count_next = count
                   + (fetch_acc   ? LINE_CNT : CNT_W'(0))
                   - (consume_acc ? CNT_W'(consume_len) : CNT_W'(0));

        if (count_next == CNT_W'(0))       state_next = ST_EMPTY;
        else if (count_next < LINE_CNT)    state_next = ST_PARTIAL;
        else if (count_next < FULL_CNT)    state_next = ST_READY;
        else                               state_next = ST_FULL;
    end

    // Window is the buffer read from head, wrapping through byte 0.
    always_comb begin
        window = '0;
        for (int i = 0; i < int'(LINE_BYTES); i++) begin
            window[i*8 +: 8] = mem_q[head_q + PTR_W'(i)];
        end
    end

    // Pointers, occupancy, controller state, error pulse and buffer storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count       <= '0;
            state_q     <= ST_EMPTY;
            consume_err <= 1'b0;
            for (int i = 0; i < int'(BUF_BYTES); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (flush) begin
            // Redirect drops bytes by resetting pointers; storage is left alone.
            head_q      <= '0;
            tail_q      <= '0;
            count       <= '0;
            state_q     <= ST_EMPTY;
            consume_err <= 1'b0;
        end else begin
            if (fetch_acc) begin
                for (int i = 0; i < int'(LINE_BYTES); i++) begin
                    mem_q[tail_q + PTR_W'(i)] <= fetch_line[i*8 +: 8];
                end
                tail_q <= tail_q + PTR_W'(LINE_BYTES);
            end
            if (consume_acc) begin
                head_q <= head_q + PTR_W'(consume_len);
            end
            count       <= count_next;
            state_q     <= state_next;
            consume_err <= consume_bad;
        end
    end

`ifdef DBQ_STALL_CNT_EN
    // Saturating count of cycles where decode wanted bytes the queue lacked.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (consume && !window_valid && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule
